draw_sprite_col: RTL
====================

Name: draw_sprite_col

Overview:
- Parametrised sprite overlay stage for the VGA pipeline. It replaces the fixed 64x64 ball drawer and is used for the ball and any later sprites.
- Position, enable and horizontal flip are latched once per frame, so the sprite never tears mid-frame.
- The ROM address is computed directly from the beam offset rather than from a running counter.
- Collision detection supports N configurable colour channels. Each channel has a live flag and a per-frame sticky flag.
- Sits between background/object drawers and the VGA output; feeds the game-logic collision inputs.

Parameters:
- SPR_W, 64, sprite width in pixels (power of two not required).
- SPR_H, 64, sprite height in pixels.
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- N_COL, 3, number of collision channels.
- COL_COLORS, {12'h321,12'h123,12'hAAA}, N_COL*12 packed 12-bit colours; channel i = bits [12i+11:12i].

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- xpos  in  12  sprite left edge, sampled at frame boundary.
- ypos  in  12  sprite top edge, sampled at frame boundary.
- enable  in  1  sprite visible, sampled at frame boundary.
- hflip  in  1  horizontal mirror, sampled at frame boundary.
- vga_in  in  `VGA_BUS_SIZE  fields: hcount[12], hsync, hblnk, vcount[12], vsync, vblnk, rgb[12].
- vga_out  out  `VGA_BUS_SIZE  same fields, delayed 3 cycles, rgb overlaid.
- pixel_addr  out  ADDR_W  synchronous sprite ROM address.
- pixel  in  4  ROM data, valid 1 cycle after pixel_addr; 0 = transparent.
- col_live  out  N_COL  per-channel hit, aligned with vga_out.
- col_frame  out  N_COL  per-channel sticky hit for the previous frame.
- frame_tick  out  1  one-cycle pulse when col_frame updates.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - vga_out all zero; pixel_addr=0; col_live=0; col_frame=0; frame_tick=0.
  - Latched xpos/ypos/enable/hflip = 0 (sprite hidden until first frame boundary).
  - Accumulators cleared.
- Frame boundary: the cycle where vga_in.vblnk rises (registered edge detect on the input bus).
  - Latch xpos, ypos, enable and hflip.
  - col_frame <= accumulator, OR-ed with any hit accepted in the same cycle.
  - Clear the accumulator.
  - frame_tick=1 for exactly that cycle.
  - The first boundary after reset produces col_frame=0.
- In-box test, using the latched position and 13-bit arithmetic so there is no wrap at 4095:
  - xl <= hcount < xl+SPR_W
  - yl <= vcount < yl+SPR_H
  - enable_l=1
  - no blanking (hblnk=0 and vblnk=0)
- Stage 0 → 1 (edge 1):
  - pixel_addr <= (vcount-yl)*SPR_W + col, where col = hcount-xl, or SPR_W-1-(hcount-xl) if hflip_l.
  - Outside the box, pixel_addr <= 0.
  - Bus and in-box flag registered.
- Stage 1 → 2 (edge 2): ROM returns pixel for the stage-1 address; bus and in-box flag delayed again.
- Stage 2 → out (edge 3):
  - If in-box and pixel!=0: rgb_out = {pixel,pixel,pixel}. Otherwise rgb_out = delayed rgb.
  - All other bus fields pass through unchanged.
  - Total latency is exactly 3 cycles, independent of parameters.
- Collision:
  - hit[i] = in-box_d2 & pixel!=0 & (rgb_d2 == COL_COLORS[i]).
  - Compared against the underlying (pre-overlay) colour.
  - col_live <= hit, registered with rgb_out.
  - Accumulator |= hit every cycle except as described at the frame boundary.
- Sprite partially off-screen (xl+SPR_W > hcount max): only the visible part is drawn. Address stays consistent with the beam offset, with no counter drift.
- A position change mid-frame has no effect until the next boundary.
- Reset mid-frame: outputs clear immediately; the pipeline refills after release; the sprite is hidden until the next boundary.

Test Plan:
- Reset release, enable=1, xpos=100, ypos=50: frame 0 shows no sprite. In frame 1, ROM pixel=4'h5 at (100,50) → vga_out.rgb=12'h555 3 cycles after vga_in hcount=100/vcount=50; pixel_addr=0 at that beam point plus 1 cycle.
- hflip=1, SPR_W=64: at hcount=xpos → pixel_addr=63; at hcount=xpos+63 → pixel_addr=0; line vcount=ypos+2 → base 128.
- Background rgb=12'h123 under an opaque sprite pixel → col_live[1]=1 aligned with vga_out. Transparent pixel (0) over 12'h123 → col_live=0 and rgb passes through.
- A hit on channel 0 only in frame k → col_frame=3'b001 with frame_tick at the start of vblank k. Frame k+1 with no hits → col_frame=0.
- xpos changes from 100 to 300 mid-frame → drawing stays at 100 until the vblank rise, then moves to 300.
- xpos=4080, SPR_W=64: no wrap to the left edge; pixels drawn only for hcount 4080..4095.
- rst_n asserted mid-line → vga_out, pixel_addr and col_* are 0 immediately, with no clock required.

Source files
------------

// File: rtl/draw_sprite_col.sv
// rtl/draw_sprite_col.sv - sprite overlay with per-frame latched placement and colour collision channels
// Three-stage pipeline: address, ROM fetch, overlay; collision flags are aligned with vga_out.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module draw_sprite_col #(
   parameter int SPR_W  = 64,
   parameter int SPR_H  = 64,
   parameter int ADDR_W = 12,
   parameter int N_COL  = 3,
   parameter logic [N_COL*12-1:0] COL_COLORS = {12'h321, 12'h123, 12'hAAA}
) (
   input  logic                     pclk,
   input  logic                     rst_n,
   input  logic [11:0]              xpos,
   input  logic [11:0]              ypos,
   input  logic                     enable,
   input  logic                     hflip,
   input  logic [`VGA_BUS_SIZE-1:0] vga_in,
   output logic [`VGA_BUS_SIZE-1:0] vga_out,
   output logic [ADDR_W-1:0]        pixel_addr,
   input  logic [3:0]               pixel,
   output logic [N_COL-1:0]         col_live,
   output logic [N_COL-1:0]         col_frame,
   output logic                     frame_tick
);

   // Bus layout: {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb}
   localparam int HC_LSB   = 28;
   localparam int HBLNK    = 26;
   localparam int VC_LSB   = 14;
   localparam int VBLNK    = 12;

   logic [11:0]              r_xl, r_yl;
   logic                     r_en, r_hflip;
   logic                     r_vblnk_d;
   logic [`VGA_BUS_SIZE-1:0] r_bus1, r_bus2;
   logic                     r_inbox1, r_inbox2;
   logic [N_COL-1:0]         r_acc;

   logic                     w_frame_start;
   logic                     w_inbox;
   logic [12:0]              w_hc, w_vc, w_xl, w_yl, w_dx, w_dy, w_col;
   logic [ADDR_W-1:0]        w_addr;
   logic [11:0]              w_rgb_out;
   logic [N_COL-1:0]         w_hit;

   assign w_frame_start = vga_in[VBLNK] & ~r_vblnk_d;

   // 13-bit compares so a sprite near x=4095 clips instead of wrapping
   assign w_hc = {1'b0, vga_in[HC_LSB +: 12]};
   assign w_vc = {1'b0, vga_in[VC_LSB +: 12]};
   assign w_xl = {1'b0, r_xl};
   assign w_yl = {1'b0, r_yl};

   assign w_inbox = r_en && !vga_in[HBLNK] && !vga_in[VBLNK]
                 && (w_hc >= w_xl) && (w_hc < w_xl + 13'(SPR_W))
                 && (w_vc >= w_yl) && (w_vc < w_yl + 13'(SPR_H));

   assign w_dx   = w_hc - w_xl;
   assign w_dy   = w_vc - w_yl;
   assign w_col  = r_hflip ? (13'(SPR_W - 1) - w_dx) : w_dx;
   assign w_addr = ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

   // Collision compares against the background colour, not the overlaid one
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_COL; i++) begin
         w_hit[i] = r_inbox2 && (pixel != 4'd0) && (r_bus2[11:0] == COL_COLORS[12*i +: 12]);
      end
   end

   assign w_rgb_out = (r_inbox2 && (pixel != 4'd0)) ? {pixel, pixel, pixel} : r_bus2[11:0];

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_xl       <= '0;
         r_yl       <= '0;
         r_en       <= 1'b0;
         r_hflip    <= 1'b0;
         r_vblnk_d  <= 1'b0;
         r_bus1     <= '0;
         r_bus2     <= '0;
         r_inbox1   <= 1'b0;
         r_inbox2   <= 1'b0;
         r_acc      <= '0;
         pixel_addr <= '0;
         vga_out    <= '0;
         col_live   <= '0;
         col_frame  <= '0;
         frame_tick <= 1'b0;
      end else begin
         r_vblnk_d  <= vga_in[VBLNK];
         frame_tick <= w_frame_start;
         if (w_frame_start) begin
            r_xl      <= xpos;
            r_yl      <= ypos;
            r_en      <= enable;
            r_hflip   <= hflip;
            col_frame <= r_acc | w_hit;
            r_acc     <= '0;
         end else begin
            r_acc     <= r_acc | w_hit;
         end

         pixel_addr <= w_inbox ? w_addr : '0;
         r_bus1     <= vga_in;
         r_inbox1   <= w_inbox;

         r_bus2     <= r_bus1;
         r_inbox2   <= r_inbox1;

         vga_out    <= {r_bus2[`VGA_BUS_SIZE-1:12], w_rgb_out};
         col_live   <= w_hit;
      end
   end

endmodule
